// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: program counter, one-cycle-latency instruction memory
// requester and a DEPTH-entry {instr, pc} queue feeding the datapath through
// a valid/ready handshake. A redirect flushes everything and restarts fetch.
// Optional build macro: FETCH_BYPASS_EN forwards a returning word straight to
// the consumer when the queue is empty, saving one cycle of fetch latency.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  // Stage p0: request side (fetch PC)
  logic [31:0]      fetch_pc_p0;
  // Stage p1: response side (one request in flight)
  logic             vld_p1;
  logic [31:0]      pc_p1;

  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [CNT_W:0]   occ;
  logic             fifo_nonempty;
  logic             bypass_hit;
  logic             push;
  logic             pop;
  logic             unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Issue decision, head/bypass output mux and queue push/pop strobes
  always_comb begin
    occ           = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
    imem_req      = !RST && !redirect_en && (occ < DEPTH_OCC);
    imem_addr     = fetch_pc_p0;
    fifo_nonempty = (count != '0);
    bypass_hit    = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass_hit    = !fifo_nonempty && vld_p1 && !redirect_en && !RST;
`endif
    instr_valid   = fifo_nonempty || bypass_hit;
    instr_out     = 32'h0;
    pc_out        = 32'h0;
    if (fifo_nonempty) begin
      instr_out = instr_q[rd_ptr];
      pc_out    = pc_q[rd_ptr];
    end else if (bypass_hit) begin
      instr_out = imem_rdata;
      pc_out    = pc_p1;
    end
    pop  = fifo_nonempty && instr_ready;
    push = vld_p1 && !redirect_en && !RST && !(bypass_hit && instr_ready);
  end

  // Control state: PC, in-flight flag, pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_en) begin
      fetch_pc_p0 <= {redirect_pc[31:2], 2'b00};
      vld_p1      <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      vld_p1 <= imem_req;
      if (imem_req) fetch_pc_p0 <= fetch_pc_p0 + 32'd4;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data path: in-flight PC capture and queue storage writes
  always_ff @(posedge CLK) begin
    if (imem_req) pc_p1 <= fetch_pc_p0;
    if (push) begin
      instr_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]    <= pc_p1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios with literal expectations,
// then randomized traffic checked each cycle against a queue-level model.
// Honours FETCH_BYPASS_EN when defined for the build.
module tb_instr_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  always #5 CLK = ~CLK;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST(RST),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .pc_out(pc_out),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc)
  );

  int          checks   = 0;
  int          failures = 0;
  bit          chk_en   = 1'b0;
  int          mem_mode = 0;
  logic        last_req = 1'b0;
  logic [31:0] last_data = 32'h0;

  // Reference state: fetch PC, one optional in-flight word, queue of entries
  bit          m_infl = 1'b0;
  logic [31:0] m_pc   = RESET_PC;
  logic [31:0] m_ipc  = 32'h0;
  logic [31:0] m_idat = 32'h0;
  logic [31:0] mq_in[$];
  logic [31:0] mq_pc[$];

  function automatic logic [31:0] memf(input logic [31:0] a, input int mode);
    return (mode == 0) ? a : (~a ^ 32'h1234_5678);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model past the edge
  always @(negedge CLK) begin
    int          n;
    bit          exp_req, exp_valid, byp;
    logic [31:0] exp_instr, exp_pc;
    last_req  = imem_req;
    last_data = memf(imem_addr, mem_mode);
    if (chk_en) begin
      n       = mq_pc.size();
      exp_req = !RST && !redirect_en && ((n + int'(m_infl)) < DEPTH);
      byp     = 1'b0;
`ifdef FETCH_BYPASS_EN
      byp     = (n == 0) && m_infl && !redirect_en && !RST;
`endif
      exp_valid = (n != 0) || byp;
      exp_instr = (n != 0) ? mq_in[0] : (byp ? m_idat : 32'h0);
      exp_pc    = (n != 0) ? mq_pc[0] : (byp ? m_ipc  : 32'h0);
      chk("m_req",   imem_req,    exp_req);
      chk("m_addr",  imem_addr,   m_pc);
      chk("m_valid", instr_valid, exp_valid);
      chk("m_instr", instr_out,   exp_instr);
      chk("m_pc",    pc_out,      exp_pc);
      if (RST) begin
        mq_in.delete(); mq_pc.delete(); m_infl = 1'b0; m_pc = RESET_PC;
      end else if (redirect_en) begin
        mq_in.delete(); mq_pc.delete(); m_infl = 1'b0;
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (instr_ready && n != 0) begin
          void'(mq_in.pop_front()); void'(mq_pc.pop_front());
        end
        if (m_infl && !(byp && instr_ready)) begin
          mq_in.push_back(m_idat); mq_pc.push_back(m_ipc);
        end
        if (exp_req) begin
          m_ipc = m_pc; m_idat = memf(m_pc, mem_mode); m_pc = m_pc + 32'd4; m_infl = 1'b1;
        end else begin
          m_infl = 1'b0;
        end
      end
    end
  end

  // Memory returns the word for last cycle's request, junk otherwise
  task automatic tick();
    @(posedge CLK);
    #1;
    imem_rdata = last_req ? last_data : $urandom;
  endtask

  task automatic smp();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    int          nreq;
    logic [31:0] wexp [4];
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000; wexp[3] = 32'h0000_0004;

    // Reset state
    tick();
    chk_en = 1'b1;
    smp();
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_addr",  imem_addr,   RESET_PC);
    chk("rst_req",   imem_req,    1'b0);
    chk("rst_instr", instr_out,   32'h0);

    // Free run, word = address
    tick(); RST = 1'b0; instr_ready = 1'b1;
    smp();
    chk("run_req0",  imem_req,  1'b1);
    chk("run_addr0", imem_addr, 32'h0);
    for (int k = 1; k < 8; k++) begin
      tick(); smp();
      chk("run_addr", imem_addr, 32'(k * 4));
      if (k < LAT) begin
        chk("run_valid_early", instr_valid, 1'b0);
      end else begin
        chk("run_valid", instr_valid, 1'b1);
        chk("run_pc",    pc_out,      32'((k - LAT) * 4));
        chk("run_instr", instr_out,   32'((k - LAT) * 4));
      end
    end

    // Stall: queue fills, requests stop, release delivers in order
    tick(); RST = 1'b1; instr_ready = 1'b0;
    tick(); RST = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (imem_req) nreq++;
      tick();
    end
    chk("stall_reqs", 32'(nreq), 32'(DEPTH));
    instr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      smp();
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_pc",    pc_out,      32'(j * 4));
      tick();
    end

    // Redirect with 3 queued entries and one in flight
    RST = 1'b1; instr_ready = 1'b0;
    tick(); RST = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    redirect_en = 1'b1; redirect_pc = 32'h0000_0103;
    smp();
    chk("redir_pre_valid", instr_valid, 1'b1);
    tick(); redirect_en = 1'b0; instr_ready = 1'b1;
    smp();
    chk("redir_valid", instr_valid, 1'b0);
    chk("redir_addr",  imem_addr,   32'h0000_0100);
    chk("redir_req",   imem_req,    1'b1);
    for (int i = 0; i < LAT; i++) tick();
    smp();
    chk("redir_first_valid", instr_valid, 1'b1);
    chk("redir_first_pc",    pc_out,      32'h0000_0100);

    // Redirect while a pop happens in the same cycle
    tick(); redirect_en = 1'b1; redirect_pc = 32'h0000_0200;
    smp();
    chk("rpop_valid_pre", instr_valid, 1'b1);
    tick(); redirect_en = 1'b0;
    smp();
    chk("rpop_valid_post", instr_valid, 1'b0);

    // Address wrap
    tick(); redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick(); redirect_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("wrap_addr", imem_addr, wexp[i]);
      tick();
    end

    // Reset mid-stream with a full queue
    instr_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    smp();
    chk("full_valid", instr_valid, 1'b1);
    tick(); RST = 1'b1;
    tick(); RST = 1'b0;
    smp();
    chk("mrst_valid", instr_valid, 1'b0);
    chk("mrst_addr",  imem_addr,   RESET_PC);
    chk("mrst_req",   imem_req,    1'b1);

    // Randomized traffic against the model
    mem_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      RST         = ($urandom_range(0, 199) == 0);
      instr_ready = ($urandom_range(0, 3) != 0) && !((c / 64) % 5 == 4);
      redirect_en = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
    end
    tick(); RST = 1'b0; redirect_en = 1'b0;
    smp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage feeding the single-cycle datapath's instruction input. Owns the program counter, issues word reads to a synchronous instruction memory with fixed one-cycle read latency, and buffers returned words with their PCs in a small FIFO. A valid/ready handshake hands instructions to the datapath. A branch/jump redirect flushes the queue and restarts fetch at a new PC.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; word-aligned.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `imem_req` out 1: read request this cycle.
- `imem_addr` out 32: word-aligned read address; bits [1:0] always 0.
- `imem_rdata` in 32: read data; valid exactly one cycle after the `imem_req` cycle.
- `instr_valid` out 1: `instr_out`/`pc_out` hold a valid instruction.
- `instr_ready` in 1: consumer accepts when high together with `instr_valid`.
- `instr_out` out 32: instruction word at queue head.
- `pc_out` out 32: address of `instr_out`.
- `redirect_en` in 1: flush and restart fetch.
- `redirect_pc` in 32: new fetch PC; bits [1:0] ignored and treated as 0.

## Operation
- State:
  - `fetch_pc` (32b).
  - `inflight` (1b): set when a request was issued last cycle.
  - `inflight_pc` (32b).
  - FIFO of `DEPTH` {instr, pc} entries with read pointer, write pointer and count (log2(DEPTH)+1 bits).
- Reset: `fetch_pc`=`RESET_PC`, `inflight`=0, count=0, pointers=0. Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr_out`=0, `pc_out`=0.
- Issue rule:
  - `imem_req` = !`RST` && !`redirect_en` && (count + `inflight` < `DEPTH`).
  - The rule uses current count and ignores a same-cycle pop, so the FIFO can never overflow.
  - `imem_addr` = `fetch_pc`.
  - On issue: `fetch_pc` += 4 (32-bit wrap, 32'hFFFF_FFFC → 0), `inflight_pc` ← `fetch_pc`.
- Response: if `inflight`=1 and no redirect this cycle, push {`imem_rdata`, `inflight_pc`} at the write pointer.
- Pop: when `instr_valid` && `instr_ready`, advance the read pointer. Push and pop in the same cycle leave count unchanged.
- `instr_valid` = (count != 0). `instr_out`/`pc_out` show the head entry combinationally from FIFO storage. When empty, both drive 0.
- Redirect (priority over everything):
  - count←0, pointers←0, `inflight`←0, `fetch_pc`←{`redirect_pc`[31:2],2'b00}.
  - The in-flight response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - A same-cycle pop is considered accepted by the consumer; the queue is flushed regardless.
- Back-to-back redirects: each one restarts; the last one wins.
- Pointers wrap modulo `DEPTH`.

## Timing
- Fetch latency, request to `instr_valid`: 2 cycles.
  - Cycle 0: request issued.
  - Cycle 1: data returns and is written at the clock edge.
  - Cycle 2: `instr_valid`=1.
- First request occurs in the first cycle with `RST`=0.
- Redirect penalty: redirect in cycle R; request to the new PC in R+1; instruction valid in R+3.
- Sustained throughput: 1 instruction/cycle while `instr_ready`=1, for `DEPTH` ≥ 2.
- Stall: with `instr_ready`=0, the queue fills to `DEPTH` and `imem_req` drops. Requests resume the cycle after count + `inflight` falls below `DEPTH`.
- Reset mid-operation: all state returns to reset values at the next edge. Any outstanding response is ignored.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When count=0 and a response arrives (no redirect), `instr_valid`=1 in that same cycle, with `instr_out`=`imem_rdata` and `pc_out`=`inflight_pc`.
  - If `instr_ready`=1, the word is consumed and not pushed; otherwise it is pushed.
  - Fetch latency becomes 1 cycle and redirect penalty R+2.
- Undefined: no bypass; latencies as in Timing.

## Test plan
- Reset then free-run with `instr_ready`=1 and memory returning word = address:
  - `imem_addr` sequence 0,4,8,…
  - First `instr_valid` 2 cycles after reset release (1 cycle with bypass), `pc_out`=0, `instr_out`=0.
  - Then one instruction per cycle, `pc_out` +4 each.
- Hold `instr_ready`=0 for 10 cycles:
  - Exactly `DEPTH` requests issued, then `imem_req`=0.
  - Release: PCs 0,4,8,12 delivered in order with no loss or duplicate.
- Redirect to 32'h0000_0103 while the queue holds 3 entries and a response is in flight:
  - Next cycle `instr_valid`=0 and `imem_addr`=32'h100.
  - First delivered `pc_out`=32'h100; no old PC ever appears.
- Redirect with `instr_valid`=1 and `instr_ready`=1 in the same cycle: queue empty afterwards, count=0, no underflow.
- Redirect to 32'hFFFF_FFF8, run free: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert `RST` for one cycle mid-stream with a full queue: `instr_valid`=0 next cycle and fetch restarts at `RESET_PC`.
